// File: rtl/r2b_converter_pp.sv
// Purpose: double-buffered row-to-block converter; rows fill one slice bank while the other drains as tile beats.
// Latency: out_valid rises the cycle after a slice's last row is accepted; out_data comes straight from storage flops.
// Backpressure: in_ready drops while the fill bank is still full; out_data and flags hold while out_valid && !out_ready.
module r2b_converter_pp #(
    parameter  int WIDTH      = 16,
    parameter  int BLOCK_SIZE = 2,
    parameter  int NUM_CORES  = 8,
    parameter  int ROW        = 2754,
    parameter  int COL        = 256,
    localparam int CHUNK_SIZE = BLOCK_SIZE * BLOCK_SIZE,
    localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WIDTH*COL-1:0]                     in_row,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]    out_data,
    output logic                                     out_slice_last,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done
);

    localparam int BEATS      = COL / BLOCK_SIZE;
    localparam int NUM_SLICES = (ROW + SLICE_ROWS - 1) / SLICE_ROWS;
    localparam int TILE_W     = BLOCK_SIZE * WIDTH;
    localparam int ROW_BITS   = WIDTH * COL;
    localparam int ROW_W      = $clog2(ROW + 1);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLOT_W     = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
    localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    localparam logic [ROW_W-1:0]   ROW_N      = ROW_W'(ROW);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLICE_ROWS - 1);
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t                         state;
    logic [ROW_W-1:0]               rows_in;
    logic [SLOT_W-1:0]              slot;
    logic                           fb;
    logic                           db;
    logic [BEAT_W-1:0]              k;
    logic [SLICE_W-1:0]             slice_out;
    logic [1:0]                     bank_full;
    // Per-slot written flags: a slot never written in a short final slice reads as zero.
    logic [1:0][SLICE_ROWS-1:0]     slot_vld;
    logic [ROW_BITS-1:0]            mem [2][SLICE_ROWS];
    logic [ROW_BITS-1:0]            row_sel;
    int                             beat_base;

    logic wr_hs;
    logic rd_hs;

    // Handshake qualifiers and beat flags, decoded from registered state only.
    always_comb begin
        in_ready       = (state == ST_RUN) && !bank_full[fb] && (rows_in != ROW_N);
        out_valid      = (state == ST_RUN) && bank_full[db];
        out_slice_last = out_valid && (k == BEAT_LAST);
        out_last       = out_slice_last && (slice_out == SLICE_LAST);
        wr_hs          = in_valid && in_ready;
        rd_hs          = out_valid && out_ready;
    end

    // Gather column block k of every row in the drain bank; slice row 0 lands at the top bits.
    always_comb begin
        out_data  = '0;
        row_sel   = '0;
        beat_base = 0;
        if (out_valid) begin
            beat_base = (BEATS - 1 - int'(k)) * TILE_W;
            for (int i = 0; i < SLICE_ROWS; i++) begin
                row_sel = slot_vld[db][i] ? mem[db][i] : '0;
                out_data[(SLICE_ROWS-1-i)*TILE_W +: TILE_W] = row_sel[beat_base +: TILE_W];
            end
        end
    end

    // Row storage: no reset needed, slot_vld gates every read.
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem[fb][slot] <= in_row;
        end
    end

    // Control FSM with fill and drain pointers; fill and drain always touch different banks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rows_in   <= '0;
            slot      <= '0;
            fb        <= 1'b0;
            db        <= 1'b0;
            k         <= '0;
            slice_out <= '0;
            bank_full <= '0;
            slot_vld  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        rows_in   <= '0;
                        slot      <= '0;
                        fb        <= 1'b0;
                        db        <= 1'b0;
                        k         <= '0;
                        slice_out <= '0;
                        bank_full <= '0;
                        slot_vld  <= '0;
                    end
                end
                ST_RUN: begin
                    if (wr_hs) begin
                        slot_vld[fb][slot] <= 1'b1;
                        rows_in            <= rows_in + 1'b1;
                        if ((slot == SLOT_LAST) || (rows_in == ROW_LAST)) begin
                            bank_full[fb] <= 1'b1;
                            fb            <= ~fb;
                            slot          <= '0;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                    if (rd_hs) begin
                        if (k == BEAT_LAST) begin
                            bank_full[db] <= 1'b0;
                            slot_vld[db]  <= '0;
                            db            <= ~db;
                            k             <= '0;
                            slice_out     <= out_last ? '0 : slice_out + 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                        if (out_last) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
